// File: rtl/int_prio_pkg.sv
// Shared types and helpers for the interrupt priority controller.
package int_prio_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Never returns 0, so an index port is always at least one bit wide.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational winner search: descending from a start index with wrap-around.
module prio_pick
  import int_prio_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int IDX_W = idx_width(N_SRC)
) (
  input  logic [N_SRC-1:0] elig,
  input  logic [IDX_W-1:0] start,
  input  logic             rr_mode,
  output logic [IDX_W-1:0] win,
  output logic             found
);

  int first;
  int idx;
  logic [IDX_W-1:0] idx_v;

  // Fixed mode is the same search with the start pinned to the top index.
  always_comb begin
    win   = '0;
    found = 1'b0;
    first = rr_mode ? int'(start) : N_SRC - 1;
    idx   = first;
    idx_v = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx   = (first - k + N_SRC) % N_SRC;
      idx_v = idx[IDX_W-1:0];
      if (!found && elig[idx_v]) begin
        found = 1'b1;
        win   = idx_v;
      end
    end
  end

endmodule

// File: rtl/int_prio_ctrl.sv
// Interrupt priority controller: edge capture, pending/mask, fixed or rotating grant.
//   state   | meaning
//   IDLE    | no grant presented; arbitrate eligible sources
//   PRESENT | irq_id held and irq_valid high until irq_ack
module int_prio_ctrl
  import int_prio_pkg::*;
#(
  parameter int N_SRC   = 8,
  parameter int RR_MODE = 0,
  localparam int IDX_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] int_reg,
  input  logic [N_SRC-1:0] mask_in,
  input  logic             irq_ack,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_id,
  output logic [N_SRC-1:0] pend_out
);

  localparam logic RR_EN = (RR_MODE != 0);

  state_t           state, state_nxt;
  logic [N_SRC-1:0] int_q;
  logic [N_SRC-1:0] pending;
  logic [IDX_W-1:0] id_q;
  logic [IDX_W-1:0] last_grant;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] pend_clr;
  logic [IDX_W-1:0] rr_start;
  logic [IDX_W-1:0] win;
  logic             found;
  logic             load;
  logic             ack_fire;

  assign rise     = int_reg & ~int_q;
  assign elig     = pending & ~mask_in;
  assign rr_start = (last_grant == '0) ? IDX_W'(N_SRC - 1) : last_grant - 1'b1;
  // Clear is applied before the new capture so a coincident rise keeps the bit set.
  assign pend_clr = ack_fire ? (N_SRC'(1) << id_q) : '0;

  prio_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .elig    (elig),
    .start   (rr_start),
    .rr_mode (RR_EN),
    .win     (win),
    .found   (found)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ack_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = PRESENT;
          load      = 1'b1;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          state_nxt = IDLE;
          ack_fire  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      int_q      <= '0;
      pending    <= '0;
      id_q       <= '0;
      last_grant <= '0;
    end else begin
      state   <= state_nxt;
      int_q   <= int_reg;
      pending <= (pending & ~pend_clr) | rise;
      if (load) begin
        id_q <= win;
      end else if (ack_fire) begin
        id_q <= '0;
      end
      if (ack_fire) begin
        last_grant <= id_q;
      end
    end
  end

  assign irq_valid = (state == PRESENT);
  assign irq_id    = id_q;
  assign pend_out  = pending;

endmodule

// File: tb/tb_int_prio_ctrl.sv
// Bench for int_prio_ctrl: vector table, corner sequences, random run vs reference model.
module tb_int_prio_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] int_reg;
  logic [7:0] mask_in;
  logic       irq_ack;

  logic       fx_valid, rr_valid;
  logic [2:0] fx_id, rr_id;
  logic [7:0] fx_pend, rr_pend;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  int_prio_ctrl #(.N_SRC(8), .RR_MODE(0)) dut_fix (
    .clk       (clk),
    .rst_n     (rst_n),
    .int_reg   (int_reg),
    .mask_in   (mask_in),
    .irq_ack   (irq_ack),
    .irq_valid (fx_valid),
    .irq_id    (fx_id),
    .pend_out  (fx_pend)
  );

  int_prio_ctrl #(.N_SRC(8), .RR_MODE(1)) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .int_reg   (int_reg),
    .mask_in   (mask_in),
    .irq_ack   (irq_ack),
    .irq_valid (rr_valid),
    .irq_id    (rr_id),
    .pend_out  (rr_pend)
  );

  // Reference model, index 0 = fixed priority, index 1 = rotating.
  logic [7:0] m_pend [2];
  logic       m_val  [2];
  int         m_id   [2];
  int         m_last [2];
  logic [7:0] m_q;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] p, input logic [7:0] msk,
                              input int rr, input int last);
    logic [7:0] e;
    int i;
    e = p & ~msk;
    if (rr == 0) begin
      for (int j = 7; j >= 0; j--) if (e[j]) return j;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        i = (last + 8 - k) % 8;
        if (e[i]) return i;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = '0;
      m_val[m]  = 1'b0;
      m_id[m]   = 0;
      m_last[m] = 0;
    end
    m_q = '0;
  endtask

  task automatic model_step();
    logic [7:0] rise;
    logic [7:0] clr;
    int w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rise = int_reg & ~m_q;
    for (int m = 0; m < 2; m++) begin
      clr = '0;
      if (m_val[m]) begin
        if (irq_ack) begin
          clr[m_id[m]] = 1'b1;
          m_last[m] = m_id[m];
          m_val[m]  = 1'b0;
          m_id[m]   = 0;
        end
      end else begin
        w = pick(m_pend[m], mask_in, m, m_last[m]);
        if (w >= 0) begin
          m_val[m] = 1'b1;
          m_id[m]  = w;
        end
      end
      m_pend[m] = (m_pend[m] & ~clr) | rise;
    end
    m_q = int_reg;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    int_reg = '0;
    mask_in = '0;
    irq_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] ir;
    logic [7:0] mk;
    logic       ak;
    logic       ev;
    logic [2:0] eid;
    logic [7:0] ep;
  } vec_t;

  vec_t vt [21];
  int   exp_rr [4];
  int   grants;
  int   got;
  logic hit;
  logic [7:0] one8;

  initial begin
    // grant order 5 then 2 from one cycle of 8'h24
    vt[0]  = '{8'h24, 8'h00, 1'b0, 1'b0, 3'd0, 8'h24};
    vt[1]  = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd5, 8'h24};
    vt[2]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h04};
    vt[3]  = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h04};
    vt[4]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    vt[5]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    // masked source stays pending, granted after unmask
    vt[6]  = '{8'h28, 8'h20, 1'b0, 1'b0, 3'd0, 8'h28};
    vt[7]  = '{8'h00, 8'h20, 1'b0, 1'b1, 3'd3, 8'h28};
    vt[8]  = '{8'h00, 8'h20, 1'b1, 1'b0, 3'd0, 8'h20};
    vt[9]  = '{8'h00, 8'h20, 1'b0, 1'b0, 3'd0, 8'h20};
    vt[10] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd5, 8'h20};
    vt[11] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    // re-pulse on the ack cycle: set beats clear
    vt[12] = '{8'h10, 8'h00, 1'b0, 1'b0, 3'd0, 8'h10};
    vt[13] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd4, 8'h10};
    vt[14] = '{8'h10, 8'h00, 1'b1, 1'b0, 3'd0, 8'h10};
    vt[15] = '{8'h10, 8'h00, 1'b0, 1'b1, 3'd4, 8'h10};
    vt[16] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    // all masked: capture only, ack in idle ignored
    vt[17] = '{8'h01, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h01};
    vt[18] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h01};
    vt[19] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 8'h01};
    vt[20] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};

    do_reset();
    chk("reset_valid", int'(fx_valid), 0);
    chk("reset_id",    int'(fx_id),    0);
    chk("reset_pend",  int'(fx_pend),  0);

    for (int v = 0; v < 21; v++) begin
      int_reg = vt[v].ir;
      mask_in = vt[v].mk;
      irq_ack = vt[v].ak;
      cyc();
      chk($sformatf("vec%0d_valid", v), int'(fx_valid), int'(vt[v].ev));
      chk($sformatf("vec%0d_id", v),    int'(fx_id),    int'(vt[v].eid));
      chk($sformatf("vec%0d_pend", v),  int'(fx_pend),  int'(vt[v].ep));
    end

    // rotating order with re-pulse after each ack
    do_reset();
    exp_rr = '{7, 6, 1, 7};
    one8 = 8'h01;
    int_reg = 8'hC2;
    for (int g = 0; g < 4; g++) begin
      hit = 1'b0;
      for (int t = 0; t < 10 && !hit; t++) begin
        cyc();
        if (rr_valid) hit = 1'b1;
      end
      got = hit ? int'(rr_id) : -1;
      chk($sformatf("rr_grant%0d", g), got, exp_rr[g]);
      if (hit) begin
        irq_ack = 1'b1;
        int_reg = 8'hC2 & ~(one8 << rr_id);
        cyc();
        irq_ack = 1'b0;
        int_reg = 8'hC2;
      end
    end
    int_reg = '0;

    // held level grants once
    do_reset();
    grants = 0;
    int_reg = 8'h04;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (fx_valid) begin
        grants++;
        irq_ack = 1'b1;
      end else begin
        irq_ack = 1'b0;
      end
    end
    int_reg = '0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      if (fx_valid) begin
        grants++;
        irq_ack = 1'b1;
      end else begin
        irq_ack = 1'b0;
      end
    end
    chk("hold_grants", grants, 1);
    chk("hold_pend",   int'(fx_pend), 0);

    // async reset mid-PRESENT, input held high through release
    do_reset();
    int_reg = 8'h01;
    cyc();
    cyc();
    chk("pre_rst_valid", int'(fx_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(fx_valid), 0);
    chk("rst_mid_pend",  int'(fx_pend),  0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    chk("rel1_valid", int'(fx_valid), 0);
    chk("rel1_pend",  int'(fx_pend),  1);
    cyc();
    chk("rel2_valid", int'(fx_valid), 1);
    chk("rel2_id",    int'(fx_id),    0);
    int_reg = '0;

    // random run against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int_reg = 8'($urandom & $urandom);
      mask_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      irq_ack = 1'($urandom_range(0, 1));
      cyc();
      chk("rnd_fx_valid", int'(fx_valid), int'(m_val[0]));
      chk("rnd_fx_id",    int'(fx_id),    m_id[0]);
      chk("rnd_fx_pend",  int'(fx_pend),  int'(m_pend[0]));
      chk("rnd_rr_valid", int'(rr_valid), int'(m_val[1]));
      chk("rnd_rr_id",    int'(rr_id),    m_id[1]);
      chk("rnd_rr_pend",  int'(rr_pend),  int'(m_pend[1]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
